// File: rtl/postcode_host.sv
// postcode_host: host-side TESTREQ/TESTACK pulse initiator.
// Runs one OUTPUT or INPUT byte transfer per accepted command.
module postcode_host #(
  parameter int PULSE_HIGH = 2,
  parameter int PULSE_LOW  = 2,
  parameter int GAP        = 64,
  parameter int POLL_LIMIT = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic       testreq,
  input  logic       testack
);

  localparam int TMX0 =
    (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int TMAX = (GAP > TMX0) ? GAP : TMX0;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(POLL_LIMIT + 1);

  localparam logic [TW-1:0] T_HI  = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] T_LO  = TW'(PULSE_LOW - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [RW-1:0] R_LST = RW'(POLL_LIMIT - 1);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_POLL = 2'b01;
  localparam logic [1:0] ST_NONE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OPOLL,
    OBIT,
    ODUMMY,
    IPOLL,
    IBIT
  } phase_t;

  state_t          state;
  phase_t          phase;
  logic [3:0]      pulse_cnt;
  logic [2:0]      bit_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   timer;
  logic [7:0]      tx_sh;
  logic [7:0]      rx_sh;
  logic            nack;
  logic            rdy;
  logic [3:0]      grp_len;

  // Number of pulses making up one group in the current phase
  always_comb begin
    grp_len = 4'd3;
    unique case (phase)
      OBIT:    grp_len = tx_sh[7] ? 4'd1 : 4'd2;
      IPOLL:   grp_len = 4'd4;
      default: grp_len = 4'd3;
    endcase
  end

  // Main sequencer: pulse timing, sampling and command completion
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= OPOLL;
      pulse_cnt  <= '0;
      bit_cnt    <= '0;
      retry_cnt  <= '0;
      timer      <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      nack       <= 1'b0;
      rdy        <= 1'b0;
      testreq    <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            testreq   <= 1'b1;
            state     <= S_HI;
            timer     <= T_HI;
            phase     <= cmd_dir ? IPOLL : OPOLL;
            tx_sh     <= cmd_data;
            rx_sh     <= '0;
            pulse_cnt <= '0;
            bit_cnt   <= 3'd7;
            retry_cnt <= '0;
            nack      <= 1'b0;
            rdy       <= 1'b0;
          end
        end

        S_HI: begin
          if (timer != '0) begin
            timer <= timer - T_ONE;
          end else begin
            testreq <= 1'b0;
            state   <= S_LO;
            timer   <= T_LO;
            if (pulse_cnt != 4'hf)
              pulse_cnt <= pulse_cnt + 4'd1;
            if (pulse_cnt == 4'd0 && !testack)
              nack <= 1'b1;
            unique case (phase)
              OPOLL:
                if (pulse_cnt == 4'd2) rdy <= testack;
              IPOLL:
                if (pulse_cnt >= 4'd3) rdy <= testack;
              IBIT:
                rx_sh <= {rx_sh[6:0], testack};
              default: ;
            endcase
          end
        end

        S_LO: begin
          if (timer != '0) begin
            timer <= timer - T_ONE;
          end else if (nack) begin
            if (pulse_cnt < grp_len) begin
              state   <= S_HI;
              testreq <= 1'b1;
              timer   <= T_HI;
            end else begin
              state <= S_GAP;
              timer <= T_GAP;
            end
          end else begin
            unique case (phase)
              IPOLL: begin
                if (pulse_cnt < 4'd4) begin
                  state   <= S_HI;
                  testreq <= 1'b1;
                  timer   <= T_HI;
                end else if (rdy) begin
                  phase   <= IBIT;
                  bit_cnt <= 3'd7;
                  state   <= S_HI;
                  testreq <= 1'b1;
                  timer   <= T_HI;
                end else if (retry_cnt == R_LST) begin
                  state <= S_GAP;
                  timer <= T_GAP;
                end else begin
                  retry_cnt <= retry_cnt + R_ONE;
                  state     <= S_HI;
                  testreq   <= 1'b1;
                  timer     <= T_HI;
                end
              end
              IBIT: begin
                if (bit_cnt == 3'd0) begin
                  state <= S_GAP;
                  timer <= T_GAP;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  state   <= S_HI;
                  testreq <= 1'b1;
                  timer   <= T_HI;
                end
              end
              default: begin
                if (pulse_cnt < grp_len) begin
                  state   <= S_HI;
                  testreq <= 1'b1;
                  timer   <= T_HI;
                end else begin
                  state <= S_GAP;
                  timer <= T_GAP;
                end
              end
            endcase
          end
        end

        S_GAP: begin
          if (timer != '0) begin
            timer <= timer - T_ONE;
          end else if (nack) begin
            state      <= S_DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_NONE;
            rsp_data   <= '0;
          end else begin
            unique case (phase)
              OPOLL: begin
                if (rdy) begin
                  phase     <= OBIT;
                  bit_cnt   <= 3'd7;
                  pulse_cnt <= '0;
                  rdy       <= 1'b0;
                  state     <= S_HI;
                  testreq   <= 1'b1;
                  timer     <= T_HI;
                end else if (retry_cnt == R_LST) begin
                  state      <= S_DONE;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_POLL;
                  rsp_data   <= '0;
                end else begin
                  retry_cnt <= retry_cnt + R_ONE;
                  pulse_cnt <= '0;
                  state     <= S_HI;
                  testreq   <= 1'b1;
                  timer     <= T_HI;
                end
              end
              OBIT: begin
                if (bit_cnt == 3'd0) begin
                  phase <= ODUMMY;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  tx_sh   <= {tx_sh[6:0], 1'b0};
                end
                pulse_cnt <= '0;
                state     <= S_HI;
                testreq   <= 1'b1;
                timer     <= T_HI;
              end
              IPOLL: begin
                state      <= S_DONE;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_POLL;
                rsp_data   <= '0;
              end
              IBIT: begin
                state      <= S_DONE;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= rx_sh;
              end
              default: begin
                state      <= S_DONE;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_OK;
                rsp_data   <= '0;
              end
            endcase
          end
        end

        S_DONE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_postcode_host.sv
// tb_postcode_host: scoreboard bench with a behavioural target model.
// Expected responses come from pulse-count arithmetic per command.
module tb_postcode_host;

  localparam int PH  = 2;
  localparam int PL  = 2;
  localparam int GP  = 64;
  localparam int LIM = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       testreq;
  logic       testack;

  postcode_host #(
    .PULSE_HIGH(PH),
    .PULSE_LOW(PL),
    .GAP(GP),
    .POLL_LIMIT(LIM)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .testreq(testreq),
    .testack(testack)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] st;
    int         pulses;
    int         rxcnt;
    logic [7:0] rxb;
    bit         chk_rx;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot = 0;

  // target configuration (set by the driver per command)
  bit         present = 1'b1;
  int         rw_cfg = 0;
  int         tw_cfg = 0;
  logic [7:0] txin = 8'h00;
  int         seq = 0;

  // target working state
  int         seen_seq = 0;
  int         rw_left = 0;
  int         tw_left = 0;
  int         cur = 0;
  int         idx_done = 0;
  int         low_run = 1000;
  int         ack_at = 0;
  int         rx_bits = -1;
  int         rx_cnt = 0;
  int         rises = 0;
  int         base = 0;
  bit         in_hi = 1'b0;
  logic [7:0] rsh = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic       ack_v;

  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // target answer for the pulse currently in flight
  always_comb begin
    ack_v = 1'b0;
    if (present) begin
      if (cur <= 2) ack_v = 1'b1;
      else if (cur == 3) ack_v = (rw_left == 0);
      else if (ack_at != 0) begin
        if (cur == ack_at) ack_v = 1'b1;
        else if (cur > ack_at && cur <= ack_at + 8)
          ack_v = txin[3'(8 - (cur - ack_at))];
      end
    end
  end

  assign testack = testreq & ack_v;

  // target model and response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge refclk);
      if (!rst_n) begin
        in_hi = 1'b0; cur = 0; idx_done = 0;
        ack_at = 0; rx_bits = -1; low_run = 1000;
      end else begin
        if (seq != seen_seq) begin
          seen_seq = seq; rw_left = rw_cfg; tw_left = tw_cfg;
          rx_bits = -1; ack_at = 0; idx_done = 0;
        end
        if (testreq) begin
          if (!in_hi) begin
            in_hi = 1'b1;
            rises++;
            cur = (low_run > 30) ? 1 : idx_done + 1;
            if (present && cur >= 4 && ack_at == 0) begin
              if (tw_left == 0) ack_at = cur;
              else tw_left--;
            end
          end
          low_run = 0;
        end else begin
          if (in_hi) begin
            in_hi = 1'b0;
            idx_done = cur;
          end
          if (low_run < 1000) low_run++;
          if (low_run == 31 && idx_done > 0) begin
            if (present) begin
              if (idx_done == 3) begin
                if (rx_bits == 8) begin
                  rx_byte = rsh; rx_cnt++; rx_bits = -1;
                end else if (rx_bits < 0) begin
                  if (rw_left > 0) rw_left--;
                  else begin rx_bits = 0; rsh = 8'h00; end
                end
              end else if (idx_done <= 2 && rx_bits >= 0 && rx_bits < 8) begin
                rsh = {rsh[6:0], idx_done == 1};
                rx_bits++;
              end
            end
            idx_done = 0;
            ack_at = 0;
          end
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = q.pop_front();
            chk("rsp_status", int'(rsp_status), int'(e.st));
            chk("rsp_data", int'(rsp_data), int'(e.data));
            chk("pulse_count", rises - base, e.pulses);
            chk("target_rx_count", rx_cnt, e.rxcnt);
            if (e.chk_rx) chk("target_rx_byte", int'(rx_byte), int'(e.rxb));
            chk("break_before_rsp", int'(low_run >= GP), 1);
            chk("ready_low_at_rsp", int'(cmd_ready), 0);
          end
        end
      end
    end
  end

  task automatic issue(bit dir, logic [7:0] d, bit pres,
                       int rw, int tw, logic [7:0] txv);
    exp_t e;
    int   w;
    present = pres; rw_cfg = rw; tw_cfg = tw; txin = txv;
    seq++;
    e.data = 8'h00; e.st = 2'b00; e.pulses = 0;
    e.rxb = d; e.chk_rx = 1'b0;
    if (!pres) begin
      e.pulses = dir ? 4 : 3; e.st = 2'b10;
    end else if (!dir) begin
      if (rw >= LIM) begin
        e.pulses = 3 * LIM; e.st = 2'b01;
      end else begin
        e.pulses = 3 * (rw + 1) + 3;
        for (int i = 0; i < 8; i++) e.pulses += d[i] ? 1 : 2;
        e.chk_rx = 1'b1;
      end
    end else begin
      if (tw >= LIM) begin
        e.pulses = 3 + LIM; e.st = 2'b01;
      end else begin
        e.pulses = 12 + tw; e.data = txv;
      end
    end
    e.rxcnt = rx_cnt + (e.chk_rx ? 1 : 0);
    q.push_back(e);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge refclk); w++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_data = d;
    @(posedge refclk); #1;
    cmd_valid = 1'b0;
    base = rises;
    chk("testreq_after_accept", int'(testreq), 1);
    chk("ready_drop_on_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (q.size() != 0 && w < 30000) begin
      @(negedge refclk); w++;
    end
    chk("rsp_timeout", q.size(), 0);
    q.delete();
    repeat (2) @(negedge refclk);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge refclk);
    chk("reset_testreq", int'(testreq), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_status", int'(rsp_status), 0);
    rst_n = 1'b1;
    @(posedge refclk); #1;
    chk("ready_after_release", int'(cmd_ready), 1);

    issue(1'b0, 8'hA5, 1'b1, 0, 0, 8'h00); wait_done();
    issue(1'b1, 8'h00, 1'b1, 0, 0, 8'h3C); wait_done();
    issue(1'b0, 8'h00, 1'b1, 2, 0, 8'h00); wait_done();
    issue(1'b1, 8'h00, 1'b1, 0, 99, 8'h00); wait_done();
    issue(1'b0, 8'h5A, 1'b0, 0, 0, 8'h00); wait_done();
    issue(1'b1, 8'h00, 1'b0, 0, 0, 8'hFF); wait_done();
    issue(1'b0, 8'hFF, 1'b1, LIM, 0, 8'h00); wait_done();
    issue(1'b0, 8'h7E, 1'b1, LIM - 1, 0, 8'h00); wait_done();
    issue(1'b1, 8'h00, 1'b1, 0, LIM - 1, 8'hC3); wait_done();

    issue(1'b0, 8'h5A, 1'b1, 0, 0, 8'h00);
    w = 0;
    while (!(rx_bits == 3 && testreq) && w < 5000) begin
      @(negedge refclk); w++;
    end
    chk("reached_bit4", int'(rx_bits == 3 && testreq), 1);
    rst_n = 1'b0;
    #1;
    chk("async_testreq_drop", int'(testreq), 0);
    chk("reset_mid_ready", int'(cmd_ready), 0);
    chk("reset_mid_rsp_valid", int'(rsp_valid), 0);
    repeat (5) @(negedge refclk);
    rst_n = 1'b1;
    @(posedge refclk); #1;
    chk("ready_after_mid_reset", int'(cmd_ready), 1);
    repeat (GP + 40) @(negedge refclk);
    chk("no_rsp_for_aborted", q.size(), 1);
    q.delete();
    issue(1'b0, 8'h81, 1'b1, 0, 0, 8'h00); wait_done();

    for (int i = 0; i < 20; i++) begin
      issue(bit'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 7) != 0),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            8'($urandom));
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
